// File: rtl/sal_dfi_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sal_dfi_mem_responder_pkg
//  Description : Shared definitions for the DFI memory responder: DDR command
//                enum and decoder, sticky error-bit positions, and the
//                storage-index layout for the default geometry.
//  Options     : SAL_DFI_RESP_TIMING_CHK_EN adds two error bits (4 -> 6).
//  Revision    : 1.0 - initial release
// ============================================================================
package sal_dfi_mem_responder_pkg;

    // Decoded DDR command. CMD_IGN covers the encodings the responder
    // does not model (MRS, ZQ and so on); they are silently dropped.
    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5,
        CMD_IGN = 3'd6
    } cmd_e;

    function automatic cmd_e decode_cmd(input logic cs_n,
                                        input logic ras_n,
                                        input logic cas_n,
                                        input logic we_n);
        cmd_e c;
        c = CMD_IGN;
        if (cs_n) begin
            c = CMD_NOP;
        end else begin
            case ({ras_n, cas_n, we_n})
                3'b011:  c = CMD_ACT;
                3'b101:  c = CMD_RD;
                3'b100:  c = CMD_WR;
                3'b010:  c = CMD_PRE;
                3'b001:  c = CMD_REF;
                3'b111:  c = CMD_NOP;
                default: c = CMD_IGN;
            endcase
        end
        return c;
    endfunction

    // Bit positions inside err_o.
    localparam int ERR_ORPHAN_WRDATA  = 0;
    localparam int ERR_BAD_BANK_STATE = 1;
    localparam int ERR_RD_COLLIDE     = 2;
    localparam int ERR_WR_OVF         = 3;
    localparam int ERR_TRCD_VIOL      = 4;
    localparam int ERR_TRP_VIOL       = 5;
    localparam int ERR_W_BASE         = 4;
    localparam int ERR_W_TCHK         = 6;

    // Default geometry; the top takes these as parameter defaults.
    localparam int DEF_BK_CNT       = 4;
    localparam int DEF_COL_BITS     = 3;
    localparam int DEF_BURST_CYCLES = 4;

    // Storage index {bank, col, beat} for the default geometry.
    localparam int STO_IDX_W = $clog2(DEF_BK_CNT) + DEF_COL_BITS
                             + $clog2(DEF_BURST_CYCLES);
    typedef logic [STO_IDX_W-1:0] sto_idx_t;

endpackage
`default_nettype wire

// File: rtl/sal_dfi_mem_responder_wfifo.sv
`default_nettype none
// ============================================================================
//  Module      : sal_dfi_resp_wfifo
//  Description : Small synchronous FIFO holding pending write locations
//                {bank, col}. The head entry is visible combinationally.
//  Ports       : clk, rst (async, active-high)
//                push/push_data  - enqueue (ignored when full)
//                pop             - dequeue head (ignored when empty)
//                head_data       - current head entry
//                full, empty     - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module sal_dfi_resp_wfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = slots[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload slots need no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/sal_dfi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sal_dfi_mem_responder
//  Description : DFI-side memory stand-in. Decodes DDR commands, tracks open
//                banks, captures write bursts into a small store and returns
//                read bursts at a fixed latency; raises sticky error flags.
//  Options     : SAL_DFI_RESP_TIMING_CHK_EN - per-bank tRCD/tRP checking,
//                adds t_rcd_i/t_rp_i and widens err_o to 6 bits.
//  Ports       : clk, rst (async, active-high)
//                dfi_cke/cs_n/ras_n/cas_n/we_n/bank/address - command channel
//                dfi_wrdata_en/wrdata/wrdata_mask             - write channel
//                dfi_rddata_valid/rddata                      - read channel
//                err_o  {[trp,trcd,] wr_ovf, rd_collide, bad_bank, orphan}
//                open_bk_o - per-bank open flags
//  Revision    : 1.0 - initial release
// ============================================================================
module sal_dfi_mem_responder
    import sal_dfi_mem_responder_pkg::*;
#(
    parameter int BK_CNT       = DEF_BK_CNT,
    parameter int ADDR_W       = 14,
    parameter int COL_BITS     = DEF_COL_BITS,
    parameter int DATA_W       = 32,
    parameter int BURST_CYCLES = DEF_BURST_CYCLES,
    parameter int RD_LAT       = 6,
    parameter int WR_FIFO_D    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      dfi_cke,
    input  logic                      dfi_cs_n,
    input  logic                      dfi_ras_n,
    input  logic                      dfi_cas_n,
    input  logic                      dfi_we_n,
    input  logic [$clog2(BK_CNT)-1:0] dfi_bank,
    input  logic [ADDR_W-1:0]         dfi_address,
    input  logic                      dfi_wrdata_en,
    input  logic [DATA_W-1:0]         dfi_wrdata,
    input  logic [DATA_W/8-1:0]       dfi_wrdata_mask,
    output logic                      dfi_rddata_valid,
    output logic [DATA_W-1:0]         dfi_rddata,
`ifdef SAL_DFI_RESP_TIMING_CHK_EN
    input  logic [7:0]                t_rcd_i,
    input  logic [7:0]                t_rp_i,
    output logic [ERR_W_TCHK-1:0]     err_o,
`else
    output logic [ERR_W_BASE-1:0]     err_o,
`endif
    output logic [BK_CNT-1:0]         open_bk_o
);

    localparam int BK_W    = $clog2(BK_CNT);
    localparam int BEAT_W  = $clog2(BURST_CYCLES);
    localparam int LOC_W   = BK_W + COL_BITS;
    localparam int IDX_W   = LOC_W + BEAT_W;
    localparam int STORE_D = 1 << IDX_W;
    localparam int STAGES  = RD_LAT - 1;
    localparam int BYTES   = DATA_W / 8;
`ifdef SAL_DFI_RESP_TIMING_CHK_EN
    localparam int ERR_W   = ERR_W_TCHK;
`else
    localparam int ERR_W   = ERR_W_BASE;
`endif
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_CYCLES - 1);

    // ------------------------------------------------------------------
    // Command decode and bank state
    // ------------------------------------------------------------------
    cmd_e                          cmd;
    logic                          bank_open;
    logic [LOC_W-1:0]              cmd_loc;
    logic                          rd_go;
    logic                          wr_go;
    logic [BK_CNT-1:0][ADDR_W-1:0] open_row;
    logic                          unused_row_dbg;

    assign cmd       = dfi_cke ? decode_cmd(dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n)
                               : CMD_NOP;
    assign bank_open = open_bk_o[dfi_bank];
    assign cmd_loc   = {dfi_bank, dfi_address[COL_BITS-1:0]};
    // RD/WR to a closed bank are flagged and dropped.
    assign rd_go     = (cmd == CMD_RD) && bank_open;
    assign wr_go     = (cmd == CMD_WR) && bank_open;

    // The latched row is kept for waveform debug only; storage ignores it.
    assign unused_row_dbg = ^open_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_bk_o <= '0;
            open_row  <= '0;
        end else begin
            case (cmd)
                CMD_ACT: begin
                    open_bk_o[dfi_bank] <= 1'b1;
                    open_row[dfi_bank]  <= dfi_address;
                end
                CMD_PRE: begin
                    if (dfi_address[10]) open_bk_o <= '0;
                    else                 open_bk_o[dfi_bank] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write path: pending-location FIFO plus beat counter
    // ------------------------------------------------------------------
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [LOC_W-1:0] fifo_head;
    logic [BEAT_W-1:0] wbeat;
    logic             wbeat_go;

    assign wbeat_go = dfi_wrdata_en && !fifo_empty;
    assign fifo_pop = wbeat_go && (wbeat == LAST_BEAT);

    // A push into a full FIFO is dropped even if the head pops in the same
    // cycle; the overflow flag reports the attempt.
    sal_dfi_resp_wfifo #(
        .DEPTH (WR_FIFO_D),
        .WIDTH (LOC_W)
    ) u_wfifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_go),
        .push_data (cmd_loc),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbeat <= '0;
        end else if (wbeat_go) begin
            wbeat <= (wbeat == LAST_BEAT) ? '0 : wbeat + 1'b1;
        end
    end

    // Storage is deliberately not reset so contents survive rst.
    logic [DATA_W-1:0] store [STORE_D];

    always_ff @(posedge clk) begin
        if (wbeat_go) begin
            for (int b = 0; b < BYTES; b++) begin
                if (!dfi_wrdata_mask[b])
                    store[{fifo_head, wbeat}][b*8 +: 8] <= dfi_wrdata[b*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: RD_LAT-1 stage delay line feeding a burst generator. The
    // extra cycle of latency is the registered data output. Reads sample
    // the store before this edge's write lands, giving read-before-write.
    // ------------------------------------------------------------------
    logic [STAGES-1:0]            pipe_vld;
    logic [STAGES-1:0][LOC_W-1:0] pipe_loc;
    logic                         rd_active;   // beats still to be sent
    logic [LOC_W-1:0]             rd_loc;
    logic [BEAT_W-1:0]            rd_beat;
    logic                         burst_start;

    assign burst_start = pipe_vld[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld         <= '0;
            pipe_loc         <= '0;
            rd_active        <= 1'b0;
            rd_loc           <= '0;
            rd_beat          <= '0;
            dfi_rddata_valid <= 1'b0;
            dfi_rddata       <= '0;
        end else begin
            pipe_vld[0] <= rd_go;
            pipe_loc[0] <= cmd_loc;
            for (int i = STAGES - 1; i > 0; i--) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_loc[i] <= pipe_loc[i-1];
            end

            if (burst_start) begin
                // A new burst always wins; any burst in flight is truncated.
                dfi_rddata_valid <= 1'b1;
                dfi_rddata       <= store[{pipe_loc[STAGES-1], {BEAT_W{1'b0}}}];
                rd_loc           <= pipe_loc[STAGES-1];
                rd_beat          <= BEAT_W'(1);
                rd_active        <= 1'b1;
            end else if (rd_active) begin
                dfi_rddata_valid <= 1'b1;
                dfi_rddata       <= store[{rd_loc, rd_beat}];
                rd_beat          <= rd_beat + 1'b1;
                if (rd_beat == LAST_BEAT) rd_active <= 1'b0;
            end else begin
                dfi_rddata_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional per-bank tRCD / tRP counters. They load one less than the
    // programmed value so that a command exactly tRCD/tRP cycles after
    // ACT/PRE sees zero and is legal.
    // ------------------------------------------------------------------
`ifdef SAL_DFI_RESP_TIMING_CHK_EN
    logic [BK_CNT-1:0][7:0] trcd_cnt;
    logic [BK_CNT-1:0][7:0] trp_cnt;
    logic [7:0]             rcd_load;
    logic [7:0]             rp_load;

    assign rcd_load = (t_rcd_i == 8'd0) ? 8'd0 : t_rcd_i - 8'd1;
    assign rp_load  = (t_rp_i  == 8'd0) ? 8'd0 : t_rp_i  - 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trcd_cnt <= '0;
            trp_cnt  <= '0;
        end else begin
            for (int b = 0; b < BK_CNT; b++) begin
                if (trcd_cnt[b] != 8'd0) trcd_cnt[b] <= trcd_cnt[b] - 8'd1;
                if (trp_cnt[b]  != 8'd0) trp_cnt[b]  <= trp_cnt[b]  - 8'd1;
            end
            if (cmd == CMD_ACT) trcd_cnt[dfi_bank] <= rcd_load;
            if (cmd == CMD_PRE) begin
                if (dfi_address[10]) begin
                    for (int b = 0; b < BK_CNT; b++) trp_cnt[b] <= rp_load;
                end else begin
                    trp_cnt[dfi_bank] <= rp_load;
                end
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    logic [ERR_W-1:0] err_set;

    always_comb begin
        err_set = '0;
        err_set[ERR_ORPHAN_WRDATA]  = dfi_wrdata_en && fifo_empty;
        err_set[ERR_BAD_BANK_STATE] = ((cmd == CMD_ACT) && bank_open)
                                   || (((cmd == CMD_RD) || (cmd == CMD_WR)) && !bank_open)
                                   || ((cmd == CMD_REF) && (|open_bk_o));
        err_set[ERR_RD_COLLIDE]     = burst_start && rd_active;
        err_set[ERR_WR_OVF]         = wr_go && fifo_full;
`ifdef SAL_DFI_RESP_TIMING_CHK_EN
        err_set[ERR_TRCD_VIOL]      = ((cmd == CMD_RD) || (cmd == CMD_WR))
                                   && (trcd_cnt[dfi_bank] != 8'd0);
        err_set[ERR_TRP_VIOL]       = (cmd == CMD_ACT) && (trp_cnt[dfi_bank] != 8'd0);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_o <= '0;
        else     err_o <= err_o | err_set;
    end

endmodule
`default_nettype wire

// File: doc/sal_dfi_mem_responder.md
Name: sal_dfi_mem_responder

Overview:
DFI-side responder that terminates the controller's DFI control, write and read channels. It is used as the memory end in block-level and subsystem benches, and as an FPGA-prototype stand-in for PHY+DRAM.
- Decodes DDR commands and tracks the open row of each bank.
- Captures write bursts into a small data store.
- Returns read bursts at a fixed read latency.
- Raises sticky protocol-error flags.

Parameters:
BK_CNT, 4, number of banks (power of 2)
ADDR_W, 14, DFI address width
COL_BITS, 3, column bits used to index storage (addr[COL_BITS-1:0])
DATA_W, 32, DFI data width per cycle
BURST_CYCLES, 4, DFI cycles per burst
RD_LAT, 6, cycles from RD command to first dfi_rddata_valid (≥2)
WR_FIFO_D, 4, pending-write FIFO depth

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
dfi_cke  in  1  clock enable; commands ignored when 0
dfi_cs_n  in  1  chip select
dfi_ras_n  in  1  RAS
dfi_cas_n  in  1  CAS
dfi_we_n  in  1  WE
dfi_bank  in  log2(BK_CNT)  bank
dfi_address  in  ADDR_W  row or column
dfi_wrdata_en  in  1  write data beat valid
dfi_wrdata  in  DATA_W  write data
dfi_wrdata_mask  in  DATA_W/8  byte mask, 1 = do not write
dfi_rddata_valid  out  1  read beat valid
dfi_rddata  out  DATA_W  read data
err_o  out  4  sticky errors {wr_ovf, rd_collide, bad_bank_state, orphan_wrdata}
open_bk_o  out  BK_CNT  per-bank open flag (debug)

Behaviour:
- Reset: all outputs 0, all banks closed, FIFOs and pipelines empty, storage not cleared.
- Command decode when cke=1 and cs_n=0, using {ras_n,cas_n,we_n}:
  - 011 ACT: open the bank, latch row.
  - 101 RD: queue a read.
  - 100 WR: queue a write.
  - 010 PRE: if addr[10]=1 close all banks, else close the bank.
  - 001 REF: requires all banks closed.
  - 111 NOP.
  - Others ignored.
- bad_bank_state sets on: ACT to an open bank; RD or WR to a closed bank; REF with any bank open. The command is still applied except RD/WR to a closed bank, which is dropped.
- Storage index = {bank, col, beat}, where col = addr[COL_BITS-1:0] and beat = 0..BURST_CYCLES-1. The row is ignored (aliasing is accepted).
- WR: push {bank, col} into the write FIFO. If the FIFO is full, set wr_ovf and drop the push.
- Write data: each cycle dfi_wrdata_en=1 writes one beat to the FIFO-head address at the current beat counter, honouring the mask per byte. After BURST_CYCLES beats, pop the head and reset the beat counter. wrdata_en with the FIFO empty sets orphan_wrdata and the data is discarded.
- RD: insert {valid, bank, col} into an RD_LAT-1 stage shift pipeline. When it exits, start a burst:
  - dfi_rddata_valid=1 for exactly BURST_CYCLES consecutive cycles, beats 0..N-1.
  - dfi_rddata is registered: first valid beat is exactly RD_LAT cycles after the RD command cycle.
- Back-to-back reads spaced ≥ BURST_CYCLES produce gapless valid. If a new burst starts while one is active, set rd_collide; the new burst restarts at beat 0 and the old one is truncated.
- Same-cycle write beat and read beat to the same storage entry: the read returns old data (read-before-write).
- err_o bits are sticky until rst. Asserting rst mid-burst aborts all activity immediately.

Optional Feature:
SAL_DFI_RESP_TIMING_CHK_EN
- Defined: adds timing checks and extends the port list.
  - New ports: t_rcd_i (8-bit) and t_rp_i (8-bit) inputs, err_o widened to 6 bits with {trp_viol, trcd_viol} as the MSBs.
  - Per-bank saturating down-counters are loaded on ACT (t_rcd_i) and on PRE (t_rp_i).
  - RD/WR while the tRCD counter is ≠0 sets trcd_viol.
  - ACT while the tRP counter is ≠0 sets trp_viol.
  - Commands still execute.
- Undefined: no counters, no extra ports, err_o is 4 bits.

Decomposition:
- SAL_DDR_PARAMS-style package holds: the command enum (ACT/RD/WR/PRE/REF/NOP) with a decode function from {cs_n,ras_n,cas_n,we_n}, error-bit index constants, and the storage-index typedef.
- One sub-module, sal_dfi_resp_wfifo: a synchronous FIFO (WR_FIFO_D × {bank,col}) with full/empty.

Test Plan:
1. ACT b1 r5; WR b1 c2; 4 beats of wrdata 0xA0..0xA3; RD b1 c2 at cycle T → rddata_valid at T+6..T+9 with data 0xA0,0xA1,0xA2,0xA3; err_o=0.
2. WR with mask 4'b0101 on beat 0, data 0xFFFFFFFF, over prior 0x11223344 → readback beat0 = 0xFF22FF44.
3. RD to closed bank 2 → bad_bank_state=1, no rddata_valid. Also ACT b0 twice → flag stays set, reset clears it.
4. RDs at T and T+2 → rd_collide=1; valid continuous T+6..T+11; beats at T+8 onward come from the second read.
5. 5 WRs with no wrdata → wr_ovf=1; then 16 beats drain 4 bursts; one more wrdata_en → orphan_wrdata=1.
6. With SAL_DFI_RESP_TIMING_CHK_EN, t_rcd_i=3: ACT at T, RD at T+2 → trcd_viol=1; RD at T+3 → no flag.
